// File: rtl/burst_mem_responder.sv
// Burst memory responder: fixed-latency, 4-beat x 64-bit bursts over a DEPTH x 256-bit line array.
// Define BURST_MEM_RESPONDER_CHECK_EN to build the sticky protocol checker that drives err_o.
module burst_mem_responder #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address_i,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [63:0] burst_i,
  output logic [63:0] burst_o,
  output logic        resp_o,
  output logic        err_o
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, BURST, RECOVER} state_t;

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [1:0]       beat_q, beat_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             is_write_q, is_write_d;
  logic [255:0]     staging_q, staging_d;
  logic [255:0]     mem_q [DEPTH];
  logic             commit_en;
  logic [255:0]     commit_line;
  logic             req_held;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^{address_i[4:0], address_i[31:5+IDX_W]};

  // The initiator must keep the request it was accepted with asserted.
  assign req_held = is_write_q ? write_i : read_i;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    beat_d      = beat_q;
    idx_d       = idx_q;
    is_write_d  = is_write_q;
    staging_d   = staging_q;
    commit_en   = 1'b0;
    commit_line = staging_q;
    case (state_q)
      IDLE: begin
        if (read_i || write_i) begin
          idx_d      = address_i[5 +: IDX_W];
          is_write_d = !read_i;
          cnt_d      = 8'(LATENCY - 1);
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (!req_held) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == 8'd0) begin
          beat_d  = 2'd0;
          state_d = BURST;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      BURST: begin
        if (is_write_q) begin
          staging_d[{beat_q, 6'b0} +: 64] = burst_i;
        end
        if (beat_q == 2'd3) begin
          // Whole line lands in one edge, so a partial write is never visible.
          commit_en   = is_write_q;
          commit_line = staging_d;
          beat_d      = 2'd0;
          state_d     = RECOVER;
        end else begin
          beat_d = beat_q + 2'd1;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      beat_q     <= '0;
      idx_q      <= '0;
      is_write_q <= 1'b0;
      staging_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      beat_q     <= beat_d;
      idx_q      <= idx_d;
      is_write_q <= is_write_d;
      staging_q  <= staging_d;
      if (commit_en) begin
        mem_q[idx_q] <= commit_line;
      end
    end
  end

  assign resp_o  = (state_q == BURST);
  assign burst_o = (resp_o && !is_write_q) ? mem_q[idx_q][{beat_q, 6'b0} +: 64] : 64'd0;

`ifdef BURST_MEM_RESPONDER_CHECK_EN
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;

  always_comb begin
    err_d  = err_q;
    addr_d = addr_q;
    if (state_q == IDLE && (read_i || write_i)) begin
      addr_d = address_i;
      if (read_i && write_i) begin
        err_d = 1'b1;
      end
    end
    if (state_q == BURST && !req_held) begin
      err_d = 1'b1;
    end
    if ((state_q == WAIT || state_q == BURST) && address_i != addr_q) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      err_q  <= err_d;
      addr_q <= addr_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed self-checking bench for burst_mem_responder (LATENCY=4, DEPTH=16).
module tb_burst_mem_responder;

  logic        clk;
  logic        reset;
  logic [31:0] address_i;
  logic        read_i;
  logic        write_i;
  logic [63:0] burst_i;
  logic [63:0] burst_o;
  logic        resp_o;
  logic        err_o;

  int checks;
  int fails;

`ifdef BURST_MEM_RESPONDER_CHECK_EN
  localparam logic ERR_ON_VIOLATION = 1'b1;
`else
  localparam logic ERR_ON_VIOLATION = 1'b0;
`endif

  burst_mem_responder #(.LATENCY(4), .DEPTH(16)) dut (
    .clk(clk), .reset(reset), .address_i(address_i), .read_i(read_i),
    .write_i(write_i), .burst_i(burst_i), .burst_o(burst_o),
    .resp_o(resp_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read burst driver: optional simultaneous write request and address change after acceptance.
  task automatic do_read(input logic [31:0] addr, input logic [31:0] addr_after,
                         input logic also_write, output logic [63:0] d [4],
                         output int first, output int nbeats, output logic gap_ok);
    for (int k = 0; k < 4; k++) d[k] = 64'hx;
    address_i = addr;
    read_i    = 1'b1;
    write_i   = also_write;
    burst_i   = 64'hDEAD_BEEF_DEAD_BEEF;
    first     = -1;
    nbeats    = 0;
    for (int t = 1; t <= 40 && nbeats < 4; t++) begin
      tick();
      if (t == 1) address_i = addr_after;
      if (resp_o) begin
        if (first < 0) first = t;
        d[nbeats] = burst_o;
        nbeats++;
      end else if (first >= 0) begin
        break;
      end
    end
    tick();
    gap_ok  = (resp_o === 1'b0) && (burst_o === 64'd0);
    read_i  = 1'b0;
    write_i = 1'b0;
    address_i = addr;
    tick();
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [63:0] beats [4],
                          output int first, output int nbeats, output logic gap_ok,
                          output logic bo_zero, output logic [255:0] pre,
                          output logic [255:0] post);
    address_i = addr;
    write_i   = 1'b1;
    read_i    = 1'b0;
    burst_i   = 64'd0;
    first     = -1;
    nbeats    = 0;
    bo_zero   = 1'b1;
    for (int t = 1; t <= 40 && nbeats < 4; t++) begin
      tick();
      if (resp_o) begin
        if (first < 0) first = t;
        if (burst_o !== 64'd0) bo_zero = 1'b0;
        burst_i = beats[nbeats];
        nbeats++;
      end else if (first >= 0) begin
        break;
      end
    end
    pre = dut.mem_q[addr[8:5]];
    tick();
    post    = dut.mem_q[addr[8:5]];
    gap_ok  = (resp_o === 1'b0) && (burst_o === 64'd0);
    write_i = 1'b0;
    burst_i = 64'd0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; address_i = '0; read_i = 1'b0; write_i = 1'b0; burst_i = '0;
    repeat (3) tick();
    checks++; if (resp_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_resp: got %b expected 0", resp_o); end
    checks++; if (burst_o !== 64'd0) begin fails++; $display("[TB] FAIL reset_burst_o: got %h expected 0", burst_o); end
    checks++; if (err_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_err: got %b expected 0", err_o); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_read();
    logic [63:0] b [4];
    logic [63:0] d [4];
    logic [255:0] pre, post;
    int first, nb;
    logic gap, bz;
    b = '{64'h1, 64'h2, 64'h3, 64'h4};
    do_write(32'h60, b, first, nb, gap, bz, pre, post);
    checks++; if (post !== {64'h4, 64'h3, 64'h2, 64'h1}) begin fails++; $display("[TB] FAIL read_setup_line3: got %h expected 4,3,2,1", post); end
    do_read(32'h60, 32'h60, 1'b0, d, first, nb, gap);
    checks++; if (first !== 5) begin fails++; $display("[TB] FAIL read_latency: got %0d expected 5", first); end
    checks++; if (nb !== 4) begin fails++; $display("[TB] FAIL read_beats: got %0d expected 4", nb); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (d[k] !== 64'(k + 1)) begin fails++; $display("[TB] FAIL read_data beat%0d: got %h expected %h", k, d[k], 64'(k + 1)); end
    end
    checks++; if (gap !== 1'b1) begin fails++; $display("[TB] FAIL read_recover_gap: got %b expected 1", gap); end
  endtask

  task automatic test_write_commit();
    logic [63:0] b [4];
    logic [63:0] d [4];
    logic [255:0] pre, post;
    int first, nb;
    logic gap, bz;
    b = '{64'hA0A0_0000_0000_00A0, 64'hA1A1_0000_0000_00A1, 64'hA2A2_0000_0000_00A2, 64'hA3A3_0000_0000_00A3};
    do_write(32'h20, b, first, nb, gap, bz, pre, post);
    checks++; if (first !== 5) begin fails++; $display("[TB] FAIL write_latency: got %0d expected 5", first); end
    checks++; if (bz !== 1'b1) begin fails++; $display("[TB] FAIL write_burst_o_zero: got %b expected 1", bz); end
    checks++; if (pre !== 256'd0) begin fails++; $display("[TB] FAIL write_no_partial: got %h expected 0", pre); end
    checks++; if (post !== {b[3], b[2], b[1], b[0]}) begin fails++; $display("[TB] FAIL write_commit: got %h expected %h", post, {b[3], b[2], b[1], b[0]}); end
    checks++; if (gap !== 1'b1) begin fails++; $display("[TB] FAIL write_recover_gap: got %b expected 1", gap); end
    do_read(32'h20, 32'h20, 1'b0, d, first, nb, gap);
    for (int k = 0; k < 4; k++) begin
      checks++; if (d[k] !== b[k]) begin fails++; $display("[TB] FAIL write_reread beat%0d: got %h expected %h", k, d[k], b[k]); end
    end
  endtask

  task automatic test_abort();
    logic [63:0] d [4];
    int first, nb, highs;
    logic gap;
    address_i = 32'h60; read_i = 1'b1;
    tick();
    tick();
    read_i = 1'b0;
    highs = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (resp_o) highs++;
    end
    checks++; if (highs !== 0) begin fails++; $display("[TB] FAIL abort_no_resp: got %0d beats expected 0", highs); end
    do_read(32'h60, 32'h60, 1'b0, d, first, nb, gap);
    checks++; if (first !== 5) begin fails++; $display("[TB] FAIL abort_next_latency: got %0d expected 5", first); end
    checks++; if (d[0] !== 64'h1 || d[3] !== 64'h4) begin fails++; $display("[TB] FAIL abort_next_data: got %h/%h expected 1/4", d[0], d[3]); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] b [4];
    logic [63:0] d [4];
    logic [255:0] pre, post;
    int first, nb;
    logic gap, bz;
    b = '{64'hC0, 64'hC1, 64'hC2, 64'hC3};
    do_read(32'h60, 32'h60, 1'b0, d, first, nb, gap);
    checks++; if (first !== 5 || nb !== 4 || gap !== 1'b1) begin fails++; $display("[TB] FAIL b2b_read1: got first=%0d beats=%0d gap=%b expected 5/4/1", first, nb, gap); end
    checks++; if (d[1] !== 64'h2) begin fails++; $display("[TB] FAIL b2b_read1_data: got %h expected 2", d[1]); end
    tick();
    do_write(32'h100, b, first, nb, gap, bz, pre, post);
    checks++; if (first !== 5 || nb !== 4 || gap !== 1'b1) begin fails++; $display("[TB] FAIL b2b_write: got first=%0d beats=%0d gap=%b expected 5/4/1", first, nb, gap); end
    tick();
    do_read(32'h100, 32'h100, 1'b0, d, first, nb, gap);
    checks++; if (first !== 5 || nb !== 4 || gap !== 1'b1) begin fails++; $display("[TB] FAIL b2b_read2: got first=%0d beats=%0d gap=%b expected 5/4/1", first, nb, gap); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (d[k] !== b[k]) begin fails++; $display("[TB] FAIL b2b_read2_data beat%0d: got %h expected %h", k, d[k], b[k]); end
    end
    checks++; if (err_o !== 1'b0) begin fails++; $display("[TB] FAIL b2b_no_err: got %b expected 0", err_o); end
  endtask

  task automatic test_simultaneous();
    logic [63:0] b [4];
    logic [63:0] d [4];
    logic [255:0] pre, post;
    int first, nb;
    logic gap, bz;
    b = '{64'hD0, 64'hD1, 64'hD2, 64'hD3};
    do_write(32'h40, b, first, nb, gap, bz, pre, post);
    tick();
    do_read(32'h40, 32'h40, 1'b1, d, first, nb, gap);
    checks++; if (first !== 5 || nb !== 4) begin fails++; $display("[TB] FAIL simul_burst: got first=%0d beats=%0d expected 5/4", first, nb); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (d[k] !== b[k]) begin fails++; $display("[TB] FAIL simul_read_data beat%0d: got %h expected %h", k, d[k], b[k]); end
    end
    checks++; if (dut.mem_q[2] !== {b[3], b[2], b[1], b[0]}) begin fails++; $display("[TB] FAIL simul_array_unchanged: got %h", dut.mem_q[2]); end
    checks++; if (err_o !== ERR_ON_VIOLATION) begin fails++; $display("[TB] FAIL simul_err: got %b expected %b", err_o, ERR_ON_VIOLATION); end
  endtask

  task automatic test_addr_latch();
    logic [63:0] d [4];
    int first, nb;
    logic gap;
    do_read(32'h60, 32'h80, 1'b0, d, first, nb, gap);
    checks++; if (d[0] !== 64'h1 || d[2] !== 64'h3) begin fails++; $display("[TB] FAIL addr_latch_data: got %h/%h expected 1/3", d[0], d[2]); end
    checks++; if (err_o !== ERR_ON_VIOLATION) begin fails++; $display("[TB] FAIL addr_latch_err: got %b expected %b", err_o, ERR_ON_VIOLATION); end
  endtask

  task automatic test_reset_mid_write();
    logic [63:0] d [4];
    int first, nb, waited;
    logic gap;
    address_i = 32'hA0; write_i = 1'b1; burst_i = 64'hE0;
    waited = 0;
    while (!resp_o && waited < 20) begin
      tick();
      waited++;
    end
    checks++; if (resp_o !== 1'b1) begin fails++; $display("[TB] FAIL rst_mid_start: got %b expected 1", resp_o); end
    burst_i = 64'hE0;
    tick();
    burst_i = 64'hE1;
    tick();
    reset = 1'b1;
    #1;
    checks++; if (resp_o !== 1'b0) begin fails++; $display("[TB] FAIL rst_mid_resp: got %b expected 0", resp_o); end
    checks++; if (err_o !== 1'b0) begin fails++; $display("[TB] FAIL rst_mid_err: got %b expected 0", err_o); end
    write_i = 1'b0; burst_i = '0;
    tick();
    reset = 1'b0;
    tick();
    checks++; if (dut.mem_q[5] !== 256'd0) begin fails++; $display("[TB] FAIL rst_mid_array: got %h expected 0", dut.mem_q[5]); end
    do_read(32'hA0, 32'hA0, 1'b0, d, first, nb, gap);
    checks++; if (first !== 5 || nb !== 4) begin fails++; $display("[TB] FAIL rst_mid_reread_burst: got first=%0d beats=%0d expected 5/4", first, nb); end
    checks++; if ({d[3], d[2], d[1], d[0]} !== 256'd0) begin fails++; $display("[TB] FAIL rst_mid_reread_data: got %h expected 0", {d[3], d[2], d[1], d[0]}); end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_read();
    test_write_commit();
    test_abort();
    test_back_to_back();
    test_simultaneous();
    test_addr_latch();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
